// File: rtl/mul_div_32.sv
// mul_div_32 -- iterative 32x32 multiplier / divider.
//
// One request is accepted at a time from IDLE. A MUL is done with 32 shift-add
// steps and a DIV with 32 restoring shift-subtract steps, one step per clock.
// A FIX cycle then applies the sign correction and registers the result. The
// result is presented for exactly one cycle in DONE.
//
// Build option: define MUL_DIV_SIGNED_EN for two's complement operands.
// Without the macro, operands and results are unsigned. Latency is the same
// in both builds.
//
// Ports:
//   in_clk        clock, all state changes on its rising edge
//   in_reset_n    asynchronous active-low reset
//   in_start      request strobe, honoured only in IDLE
//   in_opcode     4'b1000 = MUL, 4'b1001 = DIV, others ignored
//   in_a, in_b    multiplicand/dividend, multiplier/divisor
//   out_busy      high in CALC, FIX and DONE
//   out_done      one-cycle completion pulse (DONE state)
//   out_hi        product high word / remainder
//   out_lo        product low word / quotient
//   out_div_zero  last completed DIV had a zero divisor
module mul_div_32 (
  input  logic        in_clk,
  input  logic        in_reset_n,
  input  logic        in_start,
  input  logic [3:0]  in_opcode,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_busy,
  output logic        out_done,
  output logic [31:0] out_hi,
  output logic [31:0] out_lo,
  output logic        out_div_zero
);

  localparam int          DATA_W = 32;
  localparam logic [3:0]  OP_MUL = 4'b1000;
  localparam logic [3:0]  OP_DIV = 4'b1001;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t              state, state_nxt;
  logic [4:0]          iter;
  logic                is_div;
  logic                accept;
  logic                div_by_zero;

  // Operand / accumulator registers (datapath, not reset).
  logic [DATA_W-1:0]   a_raw;
  logic [DATA_W-1:0]   opd;
  logic [DATA_W-1:0]   acc_hi;
  logic [DATA_W-1:0]   acc_lo;
  logic                neg_q;
  logic                neg_r;

  logic                a_sgn, b_sgn;
  logic [DATA_W-1:0]   a_mag, b_mag;
  logic [DATA_W:0]     mul_sum;
  logic [DATA_W:0]     div_shl;
  logic                div_ge;
  logic [DATA_W-1:0]   div_diff;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   q_fix, r_fix;
  logic [DATA_W-1:0]   res_hi, res_lo;

  function automatic logic [DATA_W-1:0] neg32(input logic [DATA_W-1:0] v);
    return ~v + 32'd1;
  endfunction

  function automatic logic [2*DATA_W-1:0] neg64(input logic [2*DATA_W-1:0] v);
    return ~v + 64'd1;
  endfunction

`ifdef MUL_DIV_SIGNED_EN
  assign a_sgn = in_a[DATA_W-1];
  assign b_sgn = in_b[DATA_W-1];
`else
  assign a_sgn = 1'b0;
  assign b_sgn = 1'b0;
`endif

  assign a_mag = a_sgn ? neg32(in_a) : in_a;
  assign b_mag = b_sgn ? neg32(in_b) : in_b;

  assign accept      = (state == IDLE) && in_start &&
                       ((in_opcode == OP_MUL) || (in_opcode == OP_DIV));
  assign div_by_zero = is_div && (opd == '0);

  assign out_busy = (state != IDLE);
  assign out_done = (state == DONE);

  // One iteration step. MUL: conditional add of the multiplicand into the
  // high half, then the 64-bit pair shifts right. DIV: shift the next
  // dividend bit into the partial remainder and subtract when it fits.
  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd} : {(DATA_W+1){1'b0}});
    div_shl  = {acc_hi, acc_lo[DATA_W-1]};
    div_ge   = (div_shl >= {1'b0, opd});
    div_diff = div_shl[DATA_W-1:0] - opd;
  end

  // Sign correction applied in FIX. The quotient and product take the XOR of
  // the operand signs; the remainder follows the dividend. The
  // 0x80000000 / -1 case wraps back to 0x80000000 on its own.
  always_comb begin
    prod_fix = neg_q ? neg64({acc_hi, acc_lo}) : {acc_hi, acc_lo};
    q_fix    = neg_q ? neg32(acc_lo) : acc_lo;
    r_fix    = neg_r ? neg32(acc_hi) : acc_hi;
    res_hi   = is_div ? r_fix : prod_fix[2*DATA_W-1:DATA_W];
    res_lo   = is_div ? q_fix : prod_fix[DATA_W-1:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = CALC;
      CALC: begin
        if (div_by_zero)        state_nxt = DONE;
        else if (iter == 5'd31) state_nxt = FIX;
      end
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state        <= IDLE;
      iter         <= 5'd0;
      is_div       <= 1'b0;
      out_hi       <= '0;
      out_lo       <= '0;
      out_div_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        iter   <= 5'd0;
        is_div <= (in_opcode == OP_DIV);
      end else if (state == CALC) begin
        iter <= iter + 5'd1;
      end
      if (state == CALC && div_by_zero) begin
        out_hi       <= a_raw;
        out_lo       <= '1;
        out_div_zero <= 1'b1;
      end else if (state == FIX) begin
        out_hi       <= res_hi;
        out_lo       <= res_lo;
        out_div_zero <= 1'b0;
      end
    end
  end

  // Latch stage: magnitudes loaded into the accumulator pair.
  always_ff @(posedge in_clk) begin
    if (accept) begin
      a_raw  <= in_a;
      opd    <= (in_opcode == OP_DIV) ? b_mag : a_mag;
      acc_hi <= '0;
      acc_lo <= (in_opcode == OP_DIV) ? a_mag : b_mag;
      neg_q  <= a_sgn ^ b_sgn;
      neg_r  <= a_sgn;
    end else if (state == CALC) begin
      if (is_div) begin
        acc_hi <= div_ge ? div_diff : div_shl[DATA_W-1:0];
        acc_lo <= {acc_lo[DATA_W-2:0], div_ge};
      end else begin
        acc_hi <= mul_sum[DATA_W:1];
        acc_lo <= {mul_sum[0], acc_lo[DATA_W-1:1]};
      end
    end
  end

endmodule
